// File: rtl/addr_map_gen.sv
// Runtime-programmable SNES address mapper: NUM_WIN windows held as shadow and active
// sets. Commits are applied atomically on bus idle, and lookup is a 2-stage pipeline.
package addr_map_pkg;
  typedef struct packed {
    logic [23:0] match_val;
    logic [23:0] match_mask;
    logic [23:0] tgt_base;
    logic [23:0] tgt_mask;
    logic [3:0]  flags;     // {lorom, saveram, wr, en}
  } win_cfg_t;

  typedef struct packed {
    logic [23:0] tgt_base;
    logic [23:0] tgt_mask;
    logic        lorom;
    logic        saveram;
    logic        wr;
  } win_tgt_t;
endpackage

// Per-window storage: the shadow and active register sets, plus the stage-1 match.
module addr_map_win import addr_map_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  sel,
  input  logic [23:0] data,
  input  logic        copy,
  input  logic [23:0] addr,
  output logic        match,
  output win_tgt_t    tgt
);
  win_cfg_t shd, act;

  // The copy samples shd before this edge's write, so a concurrent write stays shadow-only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shd <= '0;
      act <= '0;
    end else begin
      if (copy) act <= shd;
      if (we) begin
        case (sel)
          3'd0:    shd.match_val  <= data;
          3'd1:    shd.match_mask <= data;
          3'd2:    shd.tgt_base   <= data;
          3'd3:    shd.tgt_mask   <= data;
          3'd4:    shd.flags      <= data[3:0];
          default: ;
        endcase
      end
    end
  end

  assign match = act.flags[0] &&
                 ((addr & act.match_mask) == (act.match_val & act.match_mask));
  assign tgt   = '{tgt_base: act.tgt_base, tgt_mask: act.tgt_mask,
                   lorom: act.flags[3], saveram: act.flags[2], wr: act.flags[1]};
endmodule

module addr_map_gen import addr_map_pkg::*; #(
  parameter int NUM_WIN   = 4,
  parameter int WIN_IDX_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [23:0]          snes_addr,
  input  logic                 addr_valid,
  input  logic                 bus_idle,
  input  logic                 cfg_we,
  input  logic [WIN_IDX_W-1:0] cfg_win,
  input  logic [2:0]           cfg_sel,
  input  logic [23:0]          cfg_data,
  input  logic                 cfg_commit,
  output logic                 cfg_busy,
  output logic                 cfg_ack,
  output logic                 map_valid,
  output logic [23:0]          map_addr,
  output logic                 map_hit,
  output logic [WIN_IDX_W-1:0] map_win,
  output logic                 map_writable,
  output logic                 map_saveram
);
  localparam int STAGES = 2;

  typedef enum logic {IDLE, PEND} state_t;
  state_t state;

  logic                 copy;
  logic [NUM_WIN-1:0]   match, s1_match;
  win_tgt_t             tgt [NUM_WIN];
  logic [23:0]          s1_addr;
  logic [STAGES-1:0]    vld_pipe;

  logic                 hit_d;
  logic [WIN_IDX_W-1:0] win_d;
  win_tgt_t             tgt_d;
  logic [23:0]          comp_d, addr_d;

  assign copy = (state == PEND) && bus_idle;

  for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
    addr_map_win u_win (
      .clk   (clk),
      .rst   (rst),
      .we    (cfg_we && (cfg_win == WIN_IDX_W'(i))),
      .sel   (cfg_sel),
      .data  (cfg_data),
      .copy  (copy),
      .addr  (snes_addr),
      .match (match[i]),
      .tgt   (tgt[i])
    );
  end

  // A commit arriving while PEND is absorbed; the copy fires one cycle after PEND is entered at the earliest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cfg_busy <= 1'b0;
      cfg_ack  <= 1'b0;
    end else begin
      cfg_ack <= 1'b0;
      case (state)
        IDLE: if (cfg_commit) begin
          state    <= PEND;
          cfg_busy <= 1'b1;
        end
        PEND: if (bus_idle) begin
          state    <= IDLE;
          cfg_busy <= 1'b0;
          cfg_ack  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 2: the descending scan leaves the lowest-index match selected.
  always_comb begin
    hit_d = 1'b0;
    win_d = '0;
    tgt_d = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (s1_match[i]) begin
        hit_d = 1'b1;
        win_d = WIN_IDX_W'(i);
        tgt_d = tgt[i];
      end
    end
    comp_d = tgt_d.lorom ? {1'b0, s1_addr[23:16], s1_addr[14:0]} : s1_addr;
    addr_d = hit_d ? (tgt_d.tgt_base | (comp_d & tgt_d.tgt_mask)) : 24'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe     <= '0;
      s1_addr      <= '0;
      s1_match     <= '0;
      map_addr     <= '0;
      map_hit      <= 1'b0;
      map_win      <= '0;
      map_writable <= 1'b0;
      map_saveram  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], addr_valid};
      if (addr_valid) begin
        s1_addr  <= snes_addr;
        s1_match <= match;
      end
      if (vld_pipe[0]) begin
        map_addr     <= addr_d;
        map_hit      <= hit_d;
        map_win      <= win_d;
        map_writable <= hit_d & tgt_d.wr;
        map_saveram  <= hit_d & tgt_d.saveram;
      end
    end
  end

  assign map_valid = vld_pipe[STAGES-1];
endmodule

// File: tb/tb_addr_map_gen.sv
// Scoreboard bench for addr_map_gen: a behavioural model predicts each lookup and commit
// handshake, and a negedge monitor compares them against the DUT.
module tb_addr_map_gen;
  localparam int NW = 3;
  localparam int IW = 2;

  logic          clk = 1'b0, rst = 1'b1;
  logic [23:0]   snes_addr = '0, cfg_data = '0;
  logic          addr_valid = 1'b0, bus_idle = 1'b0, cfg_we = 1'b0, cfg_commit = 1'b0;
  logic [IW-1:0] cfg_win = '0;
  logic [2:0]    cfg_sel = '0;
  logic          cfg_busy, cfg_ack, map_valid, map_hit, map_writable, map_saveram;
  logic [23:0]   map_addr;
  logic [IW-1:0] map_win;

  always #5 clk = ~clk;

  addr_map_gen #(.NUM_WIN(NW), .WIN_IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .snes_addr(snes_addr), .addr_valid(addr_valid),
    .bus_idle(bus_idle), .cfg_we(cfg_we), .cfg_win(cfg_win), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
    .cfg_ack(cfg_ack), .map_valid(map_valid), .map_addr(map_addr),
    .map_hit(map_hit), .map_win(map_win), .map_writable(map_writable),
    .map_saveram(map_saveram)
  );

  typedef struct packed {
    logic          hit;
    logic [IW-1:0] win;
    logic [23:0]   addr;
    logic          wr;
    logic          sv;
  } res_t;

  // Registers of each window: [0]=match val, [1]=match mask, [2]=target base, [3]=target mask.
  logic [23:0] m_sh [NW][4];
  logic [3:0]  m_shf [NW];
  logic [23:0] m_ac [NW][4];
  logic [3:0]  m_acf [NW];
  bit          m_busy, m_ack, m_v1, m_v2;
  res_t        q[$];
  res_t        m_last;
  int          total = 0, bad = 0;

  function automatic res_t ref_lookup(logic [23:0] a);
    res_t r = '0;
    logic [23:0] c;
    for (int i = 0; i < NW; i++) begin
      if (!r.hit && m_acf[i][0] && (((a ^ m_ac[i][0]) & m_ac[i][1]) == 24'h0)) begin
        c = m_acf[i][3] ? (((a >> 1) & 24'h7F8000) | (a & 24'h007FFF)) : a;
        r.hit  = 1'b1;
        r.win  = IW'(i);
        r.addr = m_ac[i][2] | (c & m_ac[i][3]);
        r.wr   = m_acf[i][1];
        r.sv   = m_acf[i][2];
      end
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model, advanced on the same edges the DUT samples.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) begin
        for (int j = 0; j < 4; j++) begin
          m_sh[i][j] = '0;
          m_ac[i][j] = '0;
        end
        m_shf[i] = '0;
        m_acf[i] = '0;
      end
      m_busy = 0; m_ack = 0; m_v1 = 0; m_v2 = 0;
      m_last = '0;
      q.delete();
    end else begin
      m_v2 = m_v1;
      m_v1 = addr_valid;
      if (addr_valid) q.push_back(ref_lookup(snes_addr));
      m_ack = m_busy && bus_idle;
      if (m_ack) begin
        m_ac   = m_sh;
        m_acf  = m_shf;
        m_busy = 0;
      end else if (!m_busy && cfg_commit) begin
        m_busy = 1;
      end
      if (cfg_we && cfg_win < NW && cfg_sel <= 3'd4) begin
        if (cfg_sel == 3'd4) m_shf[cfg_win] = cfg_data[3:0];
        else m_sh[cfg_win][cfg_sel[1:0]] = cfg_data;
      end
    end
  end

  // Monitor.
  always @(negedge clk) begin
    res_t got;
    got = {map_hit, map_win, map_addr, map_writable, map_saveram};
    if (rst) begin
      chk("reset_out", 64'({cfg_busy, cfg_ack, map_valid, got}), 64'h0);
    end else begin
      chk("busy", 64'(cfg_busy), 64'(m_busy));
      chk("ack", 64'(cfg_ack), 64'(m_ack));
      chk("valid", 64'(map_valid), 64'(m_v2));
      if (map_valid) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL lookup: got=%h want=<no lookup pending> t=%0t", got, $time);
        end else begin
          m_last = q.pop_front();
          chk("lookup", 64'(got), 64'(m_last));
        end
      end else begin
        chk("hold", 64'(got), 64'(m_last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic wr(int w, int s, logic [23:0] d);
    cfg_we = 1'b1; cfg_win = IW'(w); cfg_sel = 3'(s); cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic lookup(logic [23:0] a);
    addr_valid = 1'b1; snes_addr = a;
    tick();
    addr_valid = 1'b0;
  endtask

  task automatic commit_wait();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    for (int k = 0; k < 20 && m_busy; k++) tick();
    if (m_busy) begin
      total++; bad++;
      $display("FAIL commit_timeout: got=busy want=idle t=%0t", $time);
    end
    tick();
  endtask

  task automatic rand_wr_cycle();
    logic [23:0] d;
    int s;
    s = $urandom_range(0, 7);
    d = 24'($urandom);
    if (s == 1) d = d & 24'($urandom) & 24'($urandom);
    cfg_we = 1'($urandom_range(0, 1)); cfg_win = IW'($urandom_range(0, 3));
    cfg_sel = 3'(s); cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    bus_idle = 1'b1;
    idle(1);

    lookup(24'h008000);
    idle(3);

    wr(0, 0, 24'h008000); wr(0, 1, 24'h408000); wr(0, 2, 24'h0);
    wr(0, 3, 24'h1FFFFF); wr(0, 4, 24'h000009);
    commit_wait();
    lookup(24'h018123);
    idle(3);

    wr(1, 0, 24'h700000); wr(1, 1, 24'h708000); wr(1, 2, 24'hE00000);
    wr(1, 3, 24'h001FFF); wr(1, 4, 24'h00000F);
    commit_wait();
    lookup(24'h701234);
    idle(3);

    wr(2, 1, 24'h0); wr(2, 4, 24'h000001);
    commit_wait();
    lookup(24'h018123); lookup(24'hC00000);
    idle(3);

    // Commit held off by a busy bus.
    bus_idle = 1'b0;
    wr(0, 2, 24'h100000);
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    idle(2);
    lookup(24'h018123);
    idle(3);
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    bus_idle = 1'b1;
    idle(3);
    lookup(24'h018123);
    idle(3);

    // Writes to a nonexistent window or register select are dropped.
    wr(NW, 2, 24'hABCDEF); wr(0, 5, 24'hFFFFFF); wr(1, 7, 24'h123456);
    commit_wait();
    lookup(24'h018123); lookup(24'h701234);
    idle(3);

    lookup(24'h018123); lookup(24'h701234); lookup(24'hC00000);
    idle(4);

    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        lookup($urandom_range(0, 1) ? 24'($urandom)
                                    : (24'h700000 | 24'($urandom_range(0, 16'h7FFF))));
      end else if (r < 9) begin
        rand_wr_cycle();
      end else begin
        bus_idle = 1'b0;
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          cfg_commit = 1'($urandom_range(0, 1));
          rand_wr_cycle();
          cfg_commit = 1'b0;
        end
        bus_idle = 1'b1;
        for (int k = 0; k < 20 && m_busy; k++) rand_wr_cycle();
        if (m_busy) begin
          total++; bad++;
          $display("FAIL commit_timeout: got=busy want=idle t=%0t", $time);
        end
        idle(1);
      end
    end
    idle(4);

    // Reset mid-stream drops in-flight lookups.
    lookup(24'h018123); lookup(24'h701234);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    lookup(24'h018123);
    idle(4);
    chk("drain", 64'(q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
